mips_data_bus_bridge: RTL and testbench
=======================================

MIPS_DATA_BUS_BRIDGE -- requirements
Module: mips_data_bus_bridge

Interface
REQ-001 SHALL have ports: clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have ports: reset  input  1  asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL have ports: cpu_address  input  32  CPU data address; cpu_read  input  1; cpu_write  input  1; cpu_writedata  input  32.
REQ-004 SHALL have ports: cpu_readdata  output  32  registered load data; cpu_clk_enable  output  1  CPU advance enable (0 = stall).
REQ-005 SHALL have ports: bus_address  output  32; bus_read  output  1; bus_write  output  1; bus_byteenable  output  4; bus_writedata  output  32.
REQ-006 SHALL have ports: bus_readdata  input  32; bus_waitrequest  input  1; timeout_err  output  1  sticky bus-timeout flag.

Function
REQ-007 SHALL implement FSM states IDLE, ACCESS, DONE; reset state IDLE.
REQ-008 IDLE: cpu_read or cpu_write high -> latch request, go ACCESS, cpu_clk_enable=0 combinationally in that cycle; no request -> cpu_clk_enable=1, stay IDLE.
REQ-009 Latch: bus_address={cpu_address[31:2],2'b00}, bus_writedata=cpu_writedata, bus_byteenable=4'b1111, op=write if cpu_write else read.
REQ-010 Simultaneous cpu_read and cpu_write SHALL be treated as a write; cpu_readdata unchanged.
REQ-011 ACCESS: exactly one of bus_read/bus_write high; address, writedata, byteenable held stable; cpu_clk_enable=0.
REQ-012 Transfer completes on rising edge in ACCESS with bus_waitrequest=0; on read, bus_readdata captured into cpu_readdata on that edge; next state DONE.
REQ-013 bus_waitrequest=1 in ACCESS -> remain ACCESS, no limit unless REQ-019.
REQ-014 DONE: bus_read=bus_write=0, cpu_clk_enable=1 for exactly one cycle, then IDLE unconditionally (request inputs ignored in DONE).
REQ-015 Minimum latency: request seen in IDLE at cycle N -> bus strobe cycle N+1 -> cpu_clk_enable=1 in cycle N+2 (2 stall cycles); each waitrequest cycle adds one.
REQ-016 cpu_readdata SHALL hold its last captured value until the next completed read.
REQ-017 Back-to-back requests: request present in IDLE after DONE SHALL start a new transfer with no extra idle cycle.

Reset
REQ-018 reset=0 SHALL immediately force FSM=IDLE, bus_read=0, bus_write=0, bus_address=0, bus_writedata=0, bus_byteenable=0, cpu_readdata=0, timeout_err=0, cpu_clk_enable=0, including mid-ACCESS; in-flight transfer abandoned; after release, normal IDLE operation from next rising edge.

Configuration
REQ-019 With macro MIPS_BRIDGE_TIMEOUT_EN defined: 8-bit counter clears on ACCESS entry, increments each ACCESS cycle with waitrequest=1; upon reaching 255 -> drop strobe, set timeout_err=1 (sticky until reset), cpu_readdata=32'hDEADBEEF for reads, go DONE.
REQ-020 Without MIPS_BRIDGE_TIMEOUT_EN: no counter logic, timeout_err tied 0, ACCESS waits indefinitely.

Verification
REQ-021 Read, zero wait: cpu_read=1, cpu_address=100, bus_readdata=9, waitrequest=0 -> bus_read high one cycle with bus_address=100, cpu_clk_enable low 2 cycles, then cpu_readdata=9.
REQ-022 Write, 3 wait cycles: cpu_write=1, address 0x104, writedata 0xCAFEF00D -> bus_write held 4 cycles with stable address/data, byteenable=1111, 5 stall cycles.
REQ-023 Unaligned + simultaneous: cpu_read=cpu_write=1, address 0x103 -> single bus_write to 0x100, cpu_readdata unchanged.
REQ-024 Reset mid-ACCESS: reset=0 while bus_read=1, waitrequest=1 -> bus_read=0 and cpu_clk_enable=0 before next clk edge; post-release IDLE, cpu_readdata=0.
REQ-025 Back-to-back: two reads (addr 8 data 0x11, addr 12 data 0x22) -> second bus_read in cycle after DONE, cpu_readdata 0x11 then 0x22.
REQ-026 With MIPS_BRIDGE_TIMEOUT_EN: read with waitrequest stuck 1 -> bus_read drops after 255 wait cycles, timeout_err=1, cpu_readdata=0xDEADBEEF, cpu_clk_enable=1 one cycle.

Source files
------------

// File: rtl/mips_data_bus_bridge_if.sv
// ---------------------------------------------------------------------------
// mips_data_bus_bridge_if
//
// Groups the CPU-side data port and the memory-bus-side port of the MIPS data
// bus bridge into one bundle.
//
// Modports:
//   slave  - the bridge itself: takes CPU requests and bus responses and
//            drives load data, CPU clock enable, bus strobes and the timeout
//            flag.
//   master - the environment around the bridge (CPU core plus bus fabric, or
//            a testbench).
//
// Signals:
//   cpu_address[31:0]    CPU data address
//   cpu_read             CPU load request
//   cpu_write            CPU store request
//   cpu_writedata[31:0]  CPU store data
//   cpu_readdata[31:0]   registered load data returned to the CPU
//   cpu_clk_enable       CPU advance enable (0 = stall)
//   bus_address[31:0]    word-aligned bus address
//   bus_read             bus read strobe
//   bus_write            bus write strobe
//   bus_byteenable[3:0]  bus byte lanes (always full word)
//   bus_writedata[31:0]  bus write data
//   bus_readdata[31:0]   bus read data
//   bus_waitrequest      bus slave stall
//   timeout_err          sticky bus-timeout flag
// ---------------------------------------------------------------------------
interface mips_data_bus_bridge_if;
    logic [31:0] cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic        cpu_clk_enable;

    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [3:0]  bus_byteenable;
    logic [31:0] bus_writedata;
    logic [31:0] bus_readdata;
    logic        bus_waitrequest;
    logic        timeout_err;

    modport slave (
        input  cpu_address,
        input  cpu_read,
        input  cpu_write,
        input  cpu_writedata,
        output cpu_readdata,
        output cpu_clk_enable,
        output bus_address,
        output bus_read,
        output bus_write,
        output bus_byteenable,
        output bus_writedata,
        input  bus_readdata,
        input  bus_waitrequest,
        output timeout_err
    );

    modport master (
        output cpu_address,
        output cpu_read,
        output cpu_write,
        output cpu_writedata,
        input  cpu_readdata,
        input  cpu_clk_enable,
        input  bus_address,
        input  bus_read,
        input  bus_write,
        input  bus_byteenable,
        input  bus_writedata,
        output bus_readdata,
        output bus_waitrequest,
        input  timeout_err
    );
endinterface

// File: rtl/mips_data_bus_bridge.sv
// ---------------------------------------------------------------------------
// mips_data_bus_bridge
//
// Bridges a single-cycle MIPS CPU data port onto a waitrequest-style memory
// bus. Every CPU load or store becomes one full-word bus transfer; the CPU is
// stalled through cpu_clk_enable until the transfer completes.
//
// Ports:
//   clk     - system clock, all state on the rising edge
//   reset   - asynchronous, active-low reset (0 = reset asserted)
//   bus_if  - mips_data_bus_bridge_if.slave, CPU and bus signals
//
// Sequencing (IDLE -> ACCESS -> DONE -> IDLE):
//   IDLE    request seen: latch it, stall the CPU in this same cycle
//           (cpu_clk_enable is combinational here), move to ACCESS.
//   ACCESS  one strobe held high with stable address/data until the bus
//           drops waitrequest; read data is captured on that edge.
//   DONE    strobes low, CPU released for exactly one cycle, request inputs
//           ignored, then back to IDLE.
//   A zero-wait access therefore stalls the CPU for two cycles, plus one per
//   waitrequest cycle.
//
// Optional feature, macro MIPS_BRIDGE_TIMEOUT_EN:
//   Defined   - an 8-bit wait counter aborts an access after 255 waitrequest
//               cycles, sets the sticky timeout_err flag and returns
//               32'hDEADBEEF for reads.
//   Undefined - no counter; ACCESS waits indefinitely and timeout_err is 0.
// ---------------------------------------------------------------------------
module mips_data_bus_bridge (
    input  logic                         clk,
    input  logic                         reset,
    mips_data_bus_bridge_if.slave        bus_if
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] bus_address_reg;
    logic [31:0] bus_writedata_reg;
    logic [3:0]  bus_byteenable_reg;
    logic        bus_read_reg;
    logic        bus_write_reg;
    logic [31:0] cpu_readdata_reg;
    logic        cpu_clk_enable_next;
    logic        cpu_request;

    // Byte offset is discarded: the bus only ever sees whole words.
    logic        unused_addr_lsbs;
    assign unused_addr_lsbs = ^bus_if.cpu_address[1:0];

    assign cpu_request = bus_if.cpu_read | bus_if.cpu_write;

`ifdef MIPS_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'd254;
    localparam logic [31:0] TIMEOUT_READDATA = 32'hDEADBEEF;

    logic [7:0]  timeout_cnt_reg;
    logic        timeout_err_reg;
`endif

    // -----------------------------------------------------------------------
    // Main sequencer. All bus-facing outputs and load data are registered
    // here so the bus sees glitch-free, stable values throughout ACCESS.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg          <= IDLE;
            bus_address_reg    <= 32'd0;
            bus_writedata_reg  <= 32'd0;
            bus_byteenable_reg <= 4'd0;
            bus_read_reg       <= 1'b0;
            bus_write_reg      <= 1'b0;
            cpu_readdata_reg   <= 32'd0;
`ifdef MIPS_BRIDGE_TIMEOUT_EN
            timeout_cnt_reg    <= 8'd0;
            timeout_err_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cpu_request) begin
                        bus_address_reg    <= {bus_if.cpu_address[31:2], 2'b00};
                        bus_writedata_reg  <= bus_if.cpu_writedata;
                        bus_byteenable_reg <= 4'b1111;
                        // A simultaneous read+write request is a store; the
                        // read half is dropped so load data stays untouched.
                        bus_write_reg      <= bus_if.cpu_write;
                        bus_read_reg       <= ~bus_if.cpu_write;
`ifdef MIPS_BRIDGE_TIMEOUT_EN
                        timeout_cnt_reg    <= 8'd0;
`endif
                        state_reg          <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (!bus_if.bus_waitrequest) begin
                        if (bus_read_reg) begin
                            cpu_readdata_reg <= bus_if.bus_readdata;
                        end
                        bus_read_reg  <= 1'b0;
                        bus_write_reg <= 1'b0;
                        state_reg     <= DONE;
                    end
`ifdef MIPS_BRIDGE_TIMEOUT_EN
                    // The counter holds the number of wait cycles already
                    // spent, so seeing 254 here means this edge closes the
                    // 255th wait cycle and the access is abandoned.
                    else if (timeout_cnt_reg == TIMEOUT_LAST) begin
                        if (bus_read_reg) begin
                            cpu_readdata_reg <= TIMEOUT_READDATA;
                        end
                        bus_read_reg    <= 1'b0;
                        bus_write_reg   <= 1'b0;
                        timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
                        timeout_err_reg <= 1'b1;
                        state_reg       <= DONE;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
                    end
`endif
                end

                DONE: begin
                    // Request inputs are deliberately ignored: the CPU is
                    // only now advancing, so anything on its port belongs to
                    // the instruction that just completed.
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // CPU clock enable. In IDLE it must react to the request within the same
    // cycle, so it is decoded from the state and live request lines. Reset is
    // folded in so the CPU is frozen for as long as reset is held.
    // -----------------------------------------------------------------------
    always_comb begin
        cpu_clk_enable_next = 1'b0;
        case (state_reg)
            IDLE:    cpu_clk_enable_next = ~cpu_request;
            ACCESS:  cpu_clk_enable_next = 1'b0;
            DONE:    cpu_clk_enable_next = 1'b1;
            default: cpu_clk_enable_next = 1'b0;
        endcase
        if (!reset) begin
            cpu_clk_enable_next = 1'b0;
        end
    end

    assign bus_if.cpu_clk_enable = cpu_clk_enable_next;
    assign bus_if.cpu_readdata   = cpu_readdata_reg;
    assign bus_if.bus_address    = bus_address_reg;
    assign bus_if.bus_writedata  = bus_writedata_reg;
    assign bus_if.bus_byteenable = bus_byteenable_reg;
    assign bus_if.bus_read       = bus_read_reg;
    assign bus_if.bus_write      = bus_write_reg;

`ifdef MIPS_BRIDGE_TIMEOUT_EN
    assign bus_if.timeout_err    = timeout_err_reg;
`else
    assign bus_if.timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mips_data_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_mips_data_bus_bridge
//
// Directed bench for mips_data_bus_bridge: a table of single transactions
// with hand-computed bus address, strobe type, stall count and load data,
// followed by hand-written sequences for request-during-DONE, bus timeout
// (only when MIPS_BRIDGE_TIMEOUT_EN is defined) and reset mid-access.
// Inputs change and outputs are sampled around the falling clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips_data_bus_bridge;

    logic clk;
    logic reset;

    mips_data_bus_bridge_if bus_if ();

    mips_data_bus_bridge dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] exp_addr;
        logic        exp_write;
        logic [31:0] exp_readdata;
        int          exp_stalls;
    } vec_t;

    localparam int NVEC = 6;
    vec_t vecs [NVEC];

    int n_cmp;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Runs one CPU transaction starting in an IDLE cycle (called right after
    // a falling edge). The CPU holds its request while stalled and drops it
    // in the cycle it is released.
    task automatic run_txn(input vec_t v, input int idx);
        int  stalls;
        int  strobes;
        int  waited;
        bit  done;
        stalls  = 0;
        strobes = 0;
        waited  = 0;
        done    = 1'b0;
        bus_if.cpu_read        = v.rd;
        bus_if.cpu_write       = v.wr;
        bus_if.cpu_address     = v.addr;
        bus_if.cpu_writedata   = v.wdata;
        bus_if.bus_readdata    = v.rdata;
        bus_if.bus_waitrequest = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (bus_if.cpu_clk_enable) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (bus_if.bus_read || bus_if.bus_write) begin
                    strobes++;
                    check($sformatf("v%0d bus_address", idx), bus_if.bus_address, v.exp_addr);
                    check($sformatf("v%0d bus_byteenable", idx), {28'd0, bus_if.bus_byteenable}, 32'hF);
                    check($sformatf("v%0d bus_write", idx), {31'd0, bus_if.bus_write}, {31'd0, v.exp_write});
                    check($sformatf("v%0d bus_read", idx), {31'd0, bus_if.bus_read}, {31'd0, ~v.exp_write});
                    if (v.exp_write) begin
                        check($sformatf("v%0d bus_writedata", idx), bus_if.bus_writedata, v.wdata);
                    end
                    if (waited < v.waits) begin
                        bus_if.bus_waitrequest = 1'b1;
                        waited++;
                    end else begin
                        bus_if.bus_waitrequest = 1'b0;
                    end
                end
                @(negedge clk);
            end
        end
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL v%0d completion: cpu_clk_enable never rose within 64 cycles", idx);
        end
        check($sformatf("v%0d stall_cycles", idx), stalls, v.exp_stalls);
        check($sformatf("v%0d strobe_cycles", idx), strobes, v.waits + 1);
        check($sformatf("v%0d cpu_readdata", idx), bus_if.cpu_readdata, v.exp_readdata);
        check($sformatf("v%0d done_strobes", idx), {30'd0, bus_if.bus_read, bus_if.bus_write}, 32'd0);
`ifndef MIPS_BRIDGE_TIMEOUT_EN
        check($sformatf("v%0d timeout_err", idx), {31'd0, bus_if.timeout_err}, 32'd0);
`endif
        $display("txn %0d: rd=%0b wr=%0b addr=%h -> bus_addr=%h stalls=%0d readdata=%h",
                 idx, v.rd, v.wr, v.addr, bus_if.bus_address, stalls, bus_if.cpu_readdata);
        bus_if.cpu_read        = 1'b0;
        bus_if.cpu_write       = 1'b0;
        bus_if.bus_waitrequest = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vec_t post_rst;
`ifdef MIPS_BRIDGE_TIMEOUT_EN
        int   to_strobes;
        bit   to_done;
`endif
        n_cmp  = 0;
        n_fail = 0;

        //               rd    wr    addr          wdata         rdata         w  exp_addr      wr    readdata      stalls
        vecs[0] = '{1'b1, 1'b0, 32'd100,      32'h0,        32'd9,        0, 32'd100,      1'b0, 32'd9,        2};
        vecs[1] = '{1'b0, 1'b1, 32'h104,      32'hCAFEF00D, 32'h0BADBAD0, 3, 32'h104,      1'b1, 32'd9,        5};
        vecs[2] = '{1'b1, 1'b1, 32'h103,      32'h12345678, 32'hAAAA5555, 0, 32'h100,      1'b1, 32'd9,        2};
        vecs[3] = '{1'b1, 1'b0, 32'd8,        32'h0,        32'h11,       0, 32'd8,        1'b0, 32'h11,       2};
        vecs[4] = '{1'b1, 1'b0, 32'd12,       32'h0,        32'h22,       0, 32'd12,       1'b0, 32'h22,       2};
        vecs[5] = '{1'b1, 1'b0, 32'hFFFFFFFE, 32'h0,        32'h5A5A1234, 2, 32'hFFFFFFFC, 1'b0, 32'h5A5A1234, 4};

        // Reset state, with a request already present to show the CPU stays
        // frozen while reset is held.
        reset                  = 1'b0;
        bus_if.cpu_read        = 1'b1;
        bus_if.cpu_write       = 1'b0;
        bus_if.cpu_address     = 32'h0;
        bus_if.cpu_writedata   = 32'h0;
        bus_if.bus_readdata    = 32'h0;
        bus_if.bus_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst cpu_clk_enable", {31'd0, bus_if.cpu_clk_enable}, 32'd0);
        check("rst strobes", {30'd0, bus_if.bus_read, bus_if.bus_write}, 32'd0);
        check("rst bus_address", bus_if.bus_address, 32'd0);
        check("rst bus_writedata", bus_if.bus_writedata, 32'd0);
        check("rst bus_byteenable", {28'd0, bus_if.bus_byteenable}, 32'd0);
        check("rst cpu_readdata", bus_if.cpu_readdata, 32'd0);
        check("rst timeout_err", {31'd0, bus_if.timeout_err}, 32'd0);
        bus_if.cpu_read = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("idle cpu_clk_enable", {31'd0, bus_if.cpu_clk_enable}, 32'd1);
        @(negedge clk);

        // Table-driven transactions, issued back to back.
        for (int i = 0; i < NVEC; i++) begin
            run_txn(vecs[i], i);
        end

        // Request held through DONE must not be taken in DONE; it is picked
        // up by the following IDLE cycle instead.
        bus_if.cpu_read     = 1'b1;
        bus_if.cpu_address  = 32'h20;
        bus_if.bus_readdata = 32'h77;
        @(negedge clk);
        #1;
        check("hold access bus_read", {31'd0, bus_if.bus_read}, 32'd1);
        @(negedge clk);
        #1;
        check("hold done cpu_clk_enable", {31'd0, bus_if.cpu_clk_enable}, 32'd1);
        check("hold done cpu_readdata", bus_if.cpu_readdata, 32'h77);
        bus_if.bus_readdata = 32'h88;
        @(negedge clk);
        #1;
        check("hold idle bus_read", {31'd0, bus_if.bus_read}, 32'd0);
        check("hold idle cpu_clk_enable", {31'd0, bus_if.cpu_clk_enable}, 32'd0);
        @(negedge clk);
        #1;
        check("hold 2nd bus_read", {31'd0, bus_if.bus_read}, 32'd1);
        @(negedge clk);
        #1;
        check("hold 2nd cpu_readdata", bus_if.cpu_readdata, 32'h88);
        $display("txn hold: request held across DONE, readdata=%h", bus_if.cpu_readdata);
        bus_if.cpu_read = 1'b0;
        @(negedge clk);

`ifdef MIPS_BRIDGE_TIMEOUT_EN
        // Read against a bus that never answers.
        bus_if.cpu_read        = 1'b1;
        bus_if.cpu_address     = 32'h80;
        bus_if.bus_readdata    = 32'h1234;
        bus_if.bus_waitrequest = 1'b1;
        to_strobes = 0;
        to_done    = 1'b0;
        for (int c = 0; c < 400 && !to_done; c++) begin
            #1;
            if (bus_if.cpu_clk_enable) begin
                to_done = 1'b1;
            end else begin
                if (bus_if.bus_read) to_strobes++;
                @(negedge clk);
            end
        end
        n_cmp++;
        if (!to_done) begin
            n_fail++;
            $display("FAIL timeout completion: cpu_clk_enable never rose within 400 cycles");
        end
        check("timeout strobe_cycles", to_strobes, 255);
        check("timeout bus_read", {31'd0, bus_if.bus_read}, 32'd0);
        check("timeout timeout_err", {31'd0, bus_if.timeout_err}, 32'd1);
        check("timeout cpu_readdata", bus_if.cpu_readdata, 32'hDEADBEEF);
        $display("txn timeout: strobe_cycles=%0d readdata=%h", to_strobes, bus_if.cpu_readdata);
        bus_if.cpu_read        = 1'b0;
        bus_if.bus_waitrequest = 1'b0;
        @(negedge clk);
        #1;
        check("timeout sticky", {31'd0, bus_if.timeout_err}, 32'd1);
        @(negedge clk);
`endif

        // Reset asserted while a read is stalled on waitrequest.
        bus_if.cpu_read        = 1'b1;
        bus_if.cpu_address     = 32'h40;
        bus_if.bus_readdata    = 32'h99;
        bus_if.bus_waitrequest = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("midrst pre bus_read", {31'd0, bus_if.bus_read}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst bus_read", {31'd0, bus_if.bus_read}, 32'd0);
        check("midrst cpu_clk_enable", {31'd0, bus_if.cpu_clk_enable}, 32'd0);
        check("midrst cpu_readdata", bus_if.cpu_readdata, 32'd0);
        check("midrst bus_address", bus_if.bus_address, 32'd0);
        check("midrst timeout_err", {31'd0, bus_if.timeout_err}, 32'd0);
        $display("txn midreset: bus_read=%0b readdata=%h", bus_if.bus_read, bus_if.cpu_readdata);
        bus_if.cpu_read        = 1'b0;
        bus_if.bus_waitrequest = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("postrst idle cpu_clk_enable", {31'd0, bus_if.cpu_clk_enable}, 32'd1);
        check("postrst cpu_readdata", bus_if.cpu_readdata, 32'd0);
        @(negedge clk);

        // Normal operation resumes after reset.
        post_rst = '{1'b1, 1'b0, 32'h44, 32'h0, 32'h13579BDF, 1, 32'h44, 1'b0, 32'h13579BDF, 3};
        run_txn(post_rst, 99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
